// File: rtl/issue_scoreboard.sv
// issue_scoreboard: holds decode issue on RAW/WAW hazards against in-flight long-latency ops and drains them before serial ops
module issue_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int REG_AW = 5,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W = 3,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_vld_i,
  input  logic [REG_AW-1:0]  dec_rs1_i,
  input  logic [REG_AW-1:0]  dec_rs2_i,
  input  logic [REG_AW-1:0]  dec_rd_i,
  input  logic               dec_rd_vld_i,
  input  logic               dec_long_i,
  input  logic               dec_serial_i,
  input  logic               lu_wb_vld_i,
  input  logic [REG_AW-1:0]  lu_wb_rd_i,
  input  logic               flush_i,
  output logic               issue_rdy_o,
  output logic               issue_vld_o,
  output logic [REG_NUM-1:0] busy_o,
  output logic [CNT_W-1:0]   outst_cnt_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  output logic               err_o
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [REG_NUM-1:0] busy, busy_m, set_v, clr_v, busy_n;
  logic [CNT_W-1:0] cnt;
  logic [STALL_W-1:0] stall;
  logic [0:0] state;
  logic err, haz, rdy, iv, long_iss, wb_ok;
  assign busy_m = {busy[REG_NUM-1:1], 1'b0};
  assign haz = busy_m[dec_rs1_i] | busy_m[dec_rs2_i] | (dec_rd_vld_i & busy_m[dec_rd_i]);
  always_comb begin
    rdy = (rst | flush_i) ? 1'b0
        : (state == DRAIN) ? (cnt == '0) & ~haz
        : ~haz & ~(dec_long_i & (cnt == CNT_W'(MAX_OUTST))) & ~(dec_serial_i & (cnt != '0));
    iv = dec_vld_i & rdy;
    long_iss = iv & dec_long_i;
    wb_ok = lu_wb_vld_i & (cnt != '0) & (busy_m[lu_wb_rd_i] | (lu_wb_rd_i == '0));
    set_v = (long_iss & dec_rd_vld_i) ? REG_NUM'(1) << dec_rd_i : '0;
    clr_v = wb_ok ? REG_NUM'(1) << lu_wb_rd_i : '0;
    busy_n = (busy & ~clr_v) | set_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt <= '0;
      stall <= '0;
      err <= 1'b0;
      state <= RUN;
    end else if (flush_i) begin
      busy <= '0;
      cnt <= '0;
      state <= RUN;
    end else begin
      busy <= {busy_n[REG_NUM-1:1], 1'b0};
      cnt <= cnt + CNT_W'(long_iss) - CNT_W'(wb_ok);
      if (dec_vld_i & ~rdy & ~&stall) stall <= stall + 1'b1;
      if (lu_wb_vld_i & ~wb_ok) err <= 1'b1;
      state <= (state == RUN) ? ((dec_vld_i & dec_serial_i & (cnt != '0)) ? DRAIN : RUN)
             : (iv ? RUN : DRAIN);
    end
  end
  assign issue_rdy_o = rdy;
  assign issue_vld_o = iv;
  assign busy_o = busy;
  assign outst_cnt_o = cnt;
  assign stall_cnt_o = stall;
  assign err_o = err;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed stimulus checked every cycle against a behavioural scoreboard model plus literal expectations
module tb_issue_scoreboard;
  localparam int MAXO = 4;
  logic clk = 0, rst;
  logic dec_vld_i, dec_rd_vld_i, dec_long_i, dec_serial_i, lu_wb_vld_i, flush_i;
  logic [4:0] dec_rs1_i, dec_rs2_i, dec_rd_i, lu_wb_rd_i;
  logic issue_rdy_o, issue_vld_o, err_o;
  logic [31:0] busy_o, stall_cnt_o, m_bv, s0;
  logic [2:0] outst_cnt_o;
  int total = 0, bad = 0;
  bit mbusy[32];
  int mcnt;
  bit mdrain, merr, live = 0, m_r, m_iv, m_legal;
  longint mstall;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .dec_vld_i(dec_vld_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rd_i(dec_rd_i), .dec_rd_vld_i(dec_rd_vld_i), .dec_long_i(dec_long_i),
    .dec_serial_i(dec_serial_i), .lu_wb_vld_i(lu_wb_vld_i), .lu_wb_rd_i(lu_wb_rd_i),
    .flush_i(flush_i), .issue_rdy_o(issue_rdy_o), .issue_vld_o(issue_vld_o), .busy_o(busy_o),
    .outst_cnt_o(outst_cnt_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic bit m_rdy();
    bit haz;
    if (rst || flush_i) return 0;
    haz = mbusy[dec_rs1_i] || mbusy[dec_rs2_i] || (dec_rd_vld_i && mbusy[dec_rd_i]);
    if (mdrain) return mcnt == 0 && !haz;
    return !haz && !(dec_long_i && mcnt == MAXO) && !(dec_serial_i && mcnt != 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      mcnt = 0; mdrain = 0; merr = 0; mstall = 0; live = 1;
    end else if (flush_i) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      mcnt = 0; mdrain = 0;
    end else begin
      m_r = m_rdy();
      m_iv = dec_vld_i && m_r;
      m_legal = lu_wb_vld_i && mcnt > 0 && (lu_wb_rd_i == 0 || mbusy[lu_wb_rd_i]);
      if (lu_wb_vld_i && !m_legal) merr = 1;
      if (dec_vld_i && !m_r && mstall < 64'hFFFF_FFFF) mstall++;
      if (!mdrain && dec_vld_i && dec_serial_i && mcnt != 0) mdrain = 1;
      else if (mdrain && m_iv) mdrain = 0;
      if (m_legal) begin mbusy[lu_wb_rd_i] = 0; mcnt--; end
      if (m_iv && dec_long_i) begin
        mcnt++;
        if (dec_rd_vld_i && dec_rd_i != 0) mbusy[dec_rd_i] = 1;
      end
    end
  end

  always @(negedge clk) if (live) begin
    for (int i = 0; i < 32; i++) m_bv[i] = mbusy[i];
    chk("rdy", issue_rdy_o, m_rdy());
    chk("vld", issue_vld_o, dec_vld_i && m_rdy());
    chk("busy", busy_o, m_bv);
    chk("cnt", outst_cnt_o, mcnt);
    chk("stall", stall_cnt_o, mstall);
    chk("err", err_o, merr);
  end

  task automatic idle();
    dec_vld_i = 0; dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0; dec_rd_vld_i = 0;
    dec_long_i = 0; dec_serial_i = 0; lu_wb_vld_i = 0; lu_wb_rd_i = 0; flush_i = 0;
  endtask
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic dec(input bit l, input bit s, input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    dec_vld_i = 1; dec_long_i = l; dec_serial_i = s; dec_rd_i = d; dec_rd_vld_i = 1;
    dec_rs1_i = r1; dec_rs2_i = r2;
  endtask
  task automatic wb(input logic [4:0] r); lu_wb_vld_i = 1; lu_wb_rd_i = r; endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle(); rst = 1;
    dec(0, 0, 1, 0, 0);
    cyc(); #1;
    chk("rst_rdy", issue_rdy_o, 0); chk("rst_vld", issue_vld_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_cnt", outst_cnt_o, 0); chk("rst_err", err_o, 0);
    cyc(); rst = 0; idle(); #1;
    chk("rst_stall", stall_cnt_o, 0);
    // RAW on a pending div result
    dec(1, 0, 5, 1, 2); #1 chk("div_vld", issue_vld_o, 1);
    cyc(); dec(0, 0, 6, 5, 0); #1;
    chk("div_busy", busy_o, 32'h20); chk("div_cnt", outst_cnt_o, 1); chk("raw_rdy0", issue_rdy_o, 0);
    cyc(); #1 chk("raw_rdy1", issue_rdy_o, 0);
    cyc(); wb(5); #1 chk("raw_wb_cycle", issue_rdy_o, 0);
    cyc(); lu_wb_vld_i = 0; #1;
    chk("raw_after_wb", issue_rdy_o, 1); chk("raw_busy_clr", busy_o, 0);
    cyc(); idle(); #1 chk("raw_stall", stall_cnt_o, 3);
    // outstanding cap
    dec(1, 0, 1, 0, 0); cyc(); dec_rd_i = 2; cyc(); dec_rd_i = 3; cyc(); dec_rd_i = 4; cyc();
    dec_rd_i = 8; #1;
    chk("cap_cnt4", outst_cnt_o, 4); chk("cap_busy", busy_o, 32'h1E); chk("cap_rdy", issue_rdy_o, 0);
    wb(2); cyc(); lu_wb_vld_i = 0; #1;
    chk("cap_cnt3", outst_cnt_o, 3); chk("cap_rdy_after", issue_rdy_o, 1);
    cyc(); idle(); #1;
    chk("cap_cnt_refill", outst_cnt_o, 4); chk("cap_busy2", busy_o, 32'h11A);
    wb(1); cyc(); wb(3); cyc(); wb(4); cyc(); wb(8); cyc(); idle(); #1;
    chk("cap_drained", outst_cnt_o, 0);
    // long op to x0 counts but never marks busy
    dec(1, 0, 0, 0, 0); #1 chk("x0_vld", issue_vld_o, 1);
    cyc(); idle(); #1;
    chk("x0_busy", busy_o, 0); chk("x0_cnt", outst_cnt_o, 1);
    wb(0); cyc(); idle(); #1;
    chk("x0_cnt0", outst_cnt_o, 0); chk("x0_err", err_o, 0);
    // CSR drains two outstanding ops
    dec(1, 0, 10, 0, 0); cyc(); dec_rd_i = 11; cyc();
    dec(0, 1, 12, 0, 0); #1 chk("csr_rdy0", issue_rdy_o, 0);
    s0 = stall_cnt_o;
    cyc(); cyc(); cyc();
    wb(10); #1 chk("csr_rdy_wb1", issue_rdy_o, 0);
    cyc(); wb(11); cyc(); lu_wb_vld_i = 0; #1;
    chk("csr_rdy1", issue_rdy_o, 1); chk("csr_cnt0", outst_cnt_o, 0);
    cyc(); idle(); #1 chk("csr_stall", stall_cnt_o - s0, 5);
    dec(1, 0, 13, 0, 0); cyc(); dec(0, 0, 14, 0, 0); #1 chk("csr_back_run", issue_rdy_o, 1);
    cyc(); idle(); wb(13); cyc(); idle();
    // flush with three outstanding and a wb in the flush cycle
    dec(1, 0, 13, 0, 0); cyc(); dec_rd_i = 14; cyc(); dec_rd_i = 15; cyc();
    dec_rd_i = 16; flush_i = 1; wb(13); #1;
    chk("fl_cnt3", outst_cnt_o, 3); chk("fl_busy", busy_o, 32'hE000); chk("fl_rdy", issue_rdy_o, 0);
    s0 = stall_cnt_o;
    cyc(); idle(); #1;
    chk("fl_busy0", busy_o, 0); chk("fl_cnt0", outst_cnt_o, 0);
    chk("fl_err", err_o, 0); chk("fl_stall", stall_cnt_o, s0);
    // flush out of DRAIN
    dec(1, 0, 20, 0, 0); cyc(); dec(0, 1, 21, 0, 0); cyc();
    dec(0, 0, 22, 0, 0); #1 chk("drain_hold", issue_rdy_o, 0);
    flush_i = 1; cyc(); idle();
    dec(1, 0, 23, 0, 0); cyc(); dec(0, 0, 22, 0, 0); #1 chk("flush_run", issue_rdy_o, 1);
    cyc(); idle(); wb(23); cyc(); idle();
    // illegal writebacks
    dec(1, 0, 9, 0, 0); cyc(); idle(); wb(7); cyc(); idle(); #1;
    chk("err_cnt", outst_cnt_o, 1); chk("err_set", err_o, 1); chk("err_busy", busy_o, 32'h200);
    wb(9); cyc(); idle(); #1;
    chk("err_cnt0", outst_cnt_o, 0); chk("err_held", err_o, 1);
    wb(0); cyc(); idle(); #1 chk("err_cnt_zero_wb", outst_cnt_o, 0);
    // reset in DRAIN
    dec(1, 0, 24, 0, 0); cyc(); dec(0, 1, 25, 0, 0); cyc();
    rst = 1; #1 chk("rst_drain_rdy", issue_rdy_o, 0);
    cyc(); rst = 0; idle(); #1;
    chk("rst2_busy", busy_o, 0); chk("rst2_cnt", outst_cnt_o, 0);
    chk("rst2_stall", stall_cnt_o, 0); chk("rst2_err", err_o, 0);
    dec(1, 0, 26, 0, 0); cyc(); dec(0, 0, 27, 0, 0); #1 chk("rst2_run", issue_rdy_o, 1);
    cyc(); idle(); wb(26); cyc(); idle(); cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
